dpll_simplify_kernel: RTL
=========================

# dpll_simplify_kernel

Parametrised unit-propagation / pure-literal simplification engine for the hardware SAT solver datapath. It takes a CNF clause matrix and repeatedly applies unit-clause and pure-literal rules, each selectable by mode bit, until one of four outcomes: SAT, UNSAT, no rule applies, or a step limit is hit. It streams every implied literal, returns the reduced formula and a partial assignment, and serves as the BCP stage ahead of the branching controller.

## Interface
- NUM_VARS, 8, number of variables V (≥2); LIT_W = $clog2(V)+1
- NUM_CLAUSES, 8, clause slots C (≥2); IDX_W = $clog2(C)
- STEP_W, 16, width of step counter and limit
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  sampled only in IDLE; launches a run
- uc_en, pl_en  in  1 each  enable unit-clause / pure-literal rules, latched at start
- max_steps  in  STEP_W  propagation limit, 0 = unlimited, latched at start
- in_matrix  in  C*2V  clause c = bits [c*2V +: 2V]; [V-1:0] positive occurrences, [2V-1:V] negative
- in_valid  in  C  clause slot active
- busy  out  1  high from the accepting edge until DONE exits
- done  out  1  one-cycle pulse, result outputs valid
- sat, unsat, limit  out  1 each  outcome flags, held until next start
- prop_strobe  out  1  one-cycle pulse per propagated literal
- prop_lit  out  LIT_W  {sign (1=negative), var index}, held
- out_matrix  out  C*2V ; out_valid  out  C  reduced formula
- assign_set, assign_val  out  V each  assigned mask / polarity (1=true)
- steps  out  STEP_W  propagations performed this run

## Operation
- Reset: all outputs 0; state IDLE; internal matrix, valid, and accumulators cleared.
- States: IDLE, SCAN, DECIDE, PROP, DONE.
- IDLE + start=1: latch the inputs; clear sat/unsat/limit/assign/steps; set busy; go to SCAN with clause index 0. Start in any other state is ignored.
- SCAN: processes one clause per cycle, index 0..C-1. For valid clauses only, it accumulates:
  - any_valid
  - empty_found: row all zero
  - first unit literal: row popcount == 1, lowest index wins
  - pos_occ/neg_occ: OR of columns
  - After index C-1, go to DECIDE.
- DECIDE, in priority order:
  - empty_found → unsat=1, go to DONE.
  - !any_valid → sat=1, go to DONE.
  - Candidate literal = unit literal if uc_en and one was found; else, if pl_en, the lowest v with pos_occ[v]^neg_occ[v], with polarity from the set side; else none.
  - No candidate → DONE with sat=unsat=limit=0.
  - Candidate and max_steps≠0 and steps==max_steps → limit=1, go to DONE.
  - Otherwise: prop_lit=candidate, prop_strobe=1, set assign_set/assign_val for the variable, steps+1 (saturating), go to PROP with index 0.
- PROP: one clause per cycle.
  - Valid row containing the literal → clear its valid bit.
  - Otherwise, clear the complementary occurrence bit.
  - After index C-1, go to SCAN (accumulators cleared).
- DONE: done=1 for one cycle; out_matrix/out_valid = working copy; busy drops; go to IDLE.
- Tautological rows (x and ¬x) are not special-cased.

## Timing
- Edge 0 accepts start. With no propagation, done is high after edge C+1.
- Each propagation adds 2C+1 cycles: done after edge (C+1) + n(2C+1).
- prop_strobe is high in the cycle after the DECIDE edge, i.e. the first PROP cycle.
- Result flags are registered with done and stay stable until the next accepted start.
- Reset asserted mid-run (any state): immediate return to IDLE with all outputs 0; no done pulse.
- start held high through DONE: a new run begins on the first IDLE edge; done is not re-pulsed spuriously.

## Test plan
All scenarios use V=8, C=8 (done at edge 9 + 17n).
- in_valid=0, start → done at edge 9, sat=1, steps=0, prop_strobe never high.
- Clauses (x0), (¬x0∨x1), (¬x1∨¬x2), (x2∨x3), uc_en=1, pl_en=0:
  - prop_lit sequence 0x0, 0x1, 0xA, 0x3
  - sat=1, steps=4, assign_set=0x0F, assign_val=0x0B, done at edge 77.
- Clauses (x0), (¬x0), uc_en=1 → prop_lit 0x0, then unsat=1, steps=1, done at edge 26, out_valid=0x02 with row 1 all zero.
- Clauses (x0∨x1), (x0∨¬x1), uc_en=0, pl_en=1 → prop_lit 0x0, sat=1, steps=1, out_valid=0.
- Clauses (x0∨x1), (¬x0∨¬x1), (x0∨¬x1), (¬x0∨x1), both rules enabled → done at edge 9, sat=unsat=limit=0, out_matrix == in_matrix.
- Robustness, using the chain scenario:
  - max_steps=1 → limit=1, steps=1, done at edge 26.
  - Pulsing start while busy → no effect.
  - Reset asserted during PROP → all outputs 0, busy=0; the next start runs normally.

Source files
------------

// File: rtl/dpll_simplify_kernel.sv
// Unit-propagation / pure-literal simplification engine: scans the clause matrix,
// picks one implied literal per pass, propagates it, and repeats until a terminal outcome.
module dpll_simplify_kernel #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int STEP_W      = 16,
  localparam int LIT_W      = $clog2(NUM_VARS) + 1,
  localparam int IDX_W      = $clog2(NUM_CLAUSES),
  localparam int ROW_W      = 2 * NUM_VARS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         uc_en,
  input  logic                         pl_en,
  input  logic [STEP_W-1:0]            max_steps,
  input  logic [NUM_CLAUSES*ROW_W-1:0] in_matrix,
  input  logic [NUM_CLAUSES-1:0]       in_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         sat,
  output logic                         unsat,
  output logic                         limit,
  output logic                         prop_strobe,
  output logic [LIT_W-1:0]             prop_lit,
  output logic [NUM_CLAUSES*ROW_W-1:0] out_matrix,
  output logic [NUM_CLAUSES-1:0]       out_valid,
  output logic [NUM_VARS-1:0]          assign_set,
  output logic [NUM_VARS-1:0]          assign_val,
  output logic [STEP_W-1:0]            steps
);
  localparam int VAR_W = LIT_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DECIDE, S_PROP, S_DONE} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [ROW_W-1:0]         mat [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0]   cls_valid;
  logic                     uc_q, pl_q;
  logic [STEP_W-1:0]        max_q;
  logic                     any_valid, empty_found, unit_found;
  logic [LIT_W-1:0]         unit_lit;
  logic [NUM_VARS-1:0]      pos_occ, neg_occ;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ROW_W-1:0]    row;
  logic                row_unit;
  logic [LIT_W-1:0]    row_lit;
  logic                pure_found;
  logic [LIT_W-1:0]    pure_lit;
  logic                has_cand, at_limit, go_prop;
  logic [LIT_W-1:0]    cand;
  logic [NUM_VARS-1:0] lit_bit;
  logic [ROW_W-1:0]    lit_mask, comp_mask;
  logic                contains;

  assign row = mat[idx];

  // A row is a unit clause when exactly one occurrence bit is set.
  always_comb begin
    row_unit = (row != '0) && ((row & (row - 1'b1)) == '0);
    row_lit  = '0;
    for (int i = ROW_W - 1; i >= 0; i--)
      if (row[i])
        row_lit = (i >= NUM_VARS) ? {1'b1, VAR_W'(i - NUM_VARS)} : {1'b0, VAR_W'(i)};
  end

  always_comb begin
    pure_found = 1'b0;
    pure_lit   = '0;
    for (int v = NUM_VARS - 1; v >= 0; v--)
      if (pos_occ[v] ^ neg_occ[v]) begin
        pure_found = 1'b1;
        pure_lit   = {neg_occ[v], VAR_W'(v)};
      end
  end

  always_comb begin
    has_cand = 1'b0;
    cand     = '0;
    if (uc_q && unit_found) begin
      has_cand = 1'b1;
      cand     = unit_lit;
    end else if (pl_q && pure_found) begin
      has_cand = 1'b1;
      cand     = pure_lit;
    end
  end

  assign at_limit = (max_q != '0) && (steps == max_q);
  assign go_prop  = !empty_found && any_valid && has_cand && !at_limit;

  // During PROP the held prop_lit selects which occurrence satisfies and which is falsified.
  assign lit_bit   = {{(NUM_VARS-1){1'b0}}, 1'b1} << prop_lit[VAR_W-1:0];
  assign lit_mask  = prop_lit[LIT_W-1] ? {lit_bit, {NUM_VARS{1'b0}}} : {{NUM_VARS{1'b0}}, lit_bit};
  assign comp_mask = prop_lit[LIT_W-1] ? {{NUM_VARS{1'b0}}, lit_bit} : {lit_bit, {NUM_VARS{1'b0}}};
  assign contains  = |(row & lit_mask);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      for (int c = 0; c < NUM_CLAUSES; c++) mat[c] <= '0;
      cls_valid   <= '0;
      uc_q        <= 1'b0;
      pl_q        <= 1'b0;
      max_q       <= '0;
      any_valid   <= 1'b0;
      empty_found <= 1'b0;
      unit_found  <= 1'b0;
      unit_lit    <= '0;
      pos_occ     <= '0;
      neg_occ     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sat         <= 1'b0;
      unsat       <= 1'b0;
      limit       <= 1'b0;
      prop_strobe <= 1'b0;
      prop_lit    <= '0;
      out_matrix  <= '0;
      out_valid   <= '0;
      assign_set  <= '0;
      assign_val  <= '0;
      steps       <= '0;
    end else begin
      done        <= 1'b0;
      prop_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int c = 0; c < NUM_CLAUSES; c++) mat[c] <= in_matrix[c*ROW_W +: ROW_W];
            cls_valid   <= in_valid;
            uc_q        <= uc_en;
            pl_q        <= pl_en;
            max_q       <= max_steps;
            sat         <= 1'b0;
            unsat       <= 1'b0;
            limit       <= 1'b0;
            assign_set  <= '0;
            assign_val  <= '0;
            steps       <= '0;
            busy        <= 1'b1;
            idx         <= '0;
            any_valid   <= 1'b0;
            empty_found <= 1'b0;
            unit_found  <= 1'b0;
            pos_occ     <= '0;
            neg_occ     <= '0;
            state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (cls_valid[idx]) begin
            any_valid <= 1'b1;
            if (row == '0) empty_found <= 1'b1;
            if (row_unit && !unit_found) begin
              unit_found <= 1'b1;
              unit_lit   <= row_lit;
            end
            pos_occ <= pos_occ | row[NUM_VARS-1:0];
            neg_occ <= neg_occ | row[ROW_W-1:NUM_VARS];
          end
          if (idx == LAST_IDX) state <= S_DECIDE;
          else                 idx   <= idx + 1'b1;
        end
        S_DECIDE: begin
          if (empty_found)    unsat <= 1'b1;
          else if (!any_valid) sat  <= 1'b1;
          else if (has_cand && at_limit) limit <= 1'b1;
          if (go_prop) begin
            prop_lit                  <= cand;
            prop_strobe               <= 1'b1;
            assign_set[cand[VAR_W-1:0]] <= 1'b1;
            assign_val[cand[VAR_W-1:0]] <= ~cand[LIT_W-1];
            steps                     <= sat_inc(steps);
            idx                       <= '0;
            state                     <= S_PROP;
          end else begin
            for (int c = 0; c < NUM_CLAUSES; c++) out_matrix[c*ROW_W +: ROW_W] <= mat[c];
            out_valid <= cls_valid;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_PROP: begin
          if (cls_valid[idx] && contains) cls_valid[idx] <= 1'b0;
          else                             mat[idx]       <= row & ~comp_mask;
          if (idx == LAST_IDX) begin
            idx         <= '0;
            any_valid   <= 1'b0;
            empty_found <= 1'b0;
            unit_found  <= 1'b0;
            pos_occ     <= '0;
            neg_occ     <= '0;
            state       <= S_SCAN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
